sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Two-master to one-slave arbiter for the SRAM-like bus (req / wr / size / addr / wdata / addr_ok / data_ok / rdata). It shares a single memory port between the instruction-fetch requester and the EXE-stage data requester, which issues load/store requests via `data_sram_req`. The arbiter locks a grant while a request waits for `addr_ok`. It records the owner of every accepted request in an in-order tag FIFO and routes each `data_ok`/`rdata` back to that owner. It sits between the pipeline stages and the bus bridge.

## Interface
- `OUT_DEPTH`, 4, maximum accepted-but-unanswered requests; power of two, 2..16.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `inst_req`, `inst_wr`  in  1  instruction master request, write flag.
- `inst_size`  in  2  0=byte, 1=half, 2=word.
- `inst_addr`, `inst_wdata`  in  32  address, write data.
- `inst_addr_ok`, `inst_data_ok`  out  1  address accepted, response valid for instruction master.
- `inst_rdata`  out  32  read data.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`  in  1/1/2/32/32  data master, same meaning as above.
- `data_addr_ok`, `data_data_ok`  out  1  data master handshake.
- `data_rdata`  out  32  read data.
- `m_req`, `m_wr`  out  1  slave request, write flag.
- `m_size`  out  2  slave size.
- `m_addr`, `m_wdata`  out  32  slave address, write data.
- `m_addr_ok`, `m_data_ok`  in  1  slave handshake.
- `m_rdata`  in  32  slave read data.
- `err_unexp`  out  1  sticky: `m_data_ok` arrived with the tag FIFO empty.

## Operation
- Grant FSM states:
  - IDLE: no lock.
  - LOCK_I: instruction master owns the slave request.
  - LOCK_D: data master owns the slave request.
- In IDLE the grant is combinational with fixed priority: data over instruction.
  - `sel = data_req ? D : inst_req ? I : none`.
- In LOCK_x the grant is x regardless of the other master's request.
- `full = (count == OUT_DEPTH)`.
- `m_req = granted master's req & ~full`. `m_wr`, `m_size`, `m_addr`, `m_wdata` mux from the granted master; they are 0 when nothing is granted.
- `inst_addr_ok = m_addr_ok & m_req & grant==I`. `data_addr_ok` likewise for D.
- FSM transitions:
  - IDLE → LOCK_x when `m_req & ~m_addr_ok` with x granted.
  - LOCK_x → IDLE when `m_req & m_addr_ok`.
  - When full, the master keeps its req high and the FSM stays IDLE/LOCK_x; no `m_req` is issued.
- Masters must hold req and payload stable until addr_ok; the arbiter does not check this.
- Tag FIFO: 1-bit tags (0=I, 1=D), `OUT_DEPTH` entries, write pointer, read pointer, `count` of width clog2(OUT_DEPTH)+1.
  - Push the owner tag on `m_req & m_addr_ok`.
  - Pop on `m_data_ok & count!=0`.
  - Push and pop in the same cycle: count unchanged, both pointers advance; pointers wrap modulo `OUT_DEPTH`.
- Response routing:
  - `inst_data_ok = m_data_ok & count!=0 & head==0`.
  - `data_data_ok = m_data_ok & count!=0 & head==1`.
  - `inst_rdata = data_rdata = m_rdata`, always broadcast.
- `m_data_ok` with `count==0`: no pop, no master `data_ok`, `err_unexp` set to 1 until reset.
- A response in the same cycle as the matching acceptance (count 0 → push and data_ok together) is an error case: `err_unexp` sets.

## Timing
- Reset:
  - FSM IDLE; pointers and count 0; `err_unexp` 0.
  - All handshake outputs 0 except `inst_rdata`/`data_rdata`, which follow `m_rdata`.
- Zero-cycle combinational paths:
  - req → `m_req`.
  - `m_addr_ok` → `*_addr_ok`.
  - `m_data_ok` → `*_data_ok`.
- The arbiter adds no added latency.
- Lock, FIFO and count updates take effect at the next rising edge.
- Back-to-back acceptances are possible every cycle until `count == OUT_DEPTH`. The full condition does not consider a same-cycle pop: it is conservative by one cycle.
- Reset mid-transaction drops all outstanding tags; responses after reset set `err_unexp`.

## Test plan
- Single read: `data_req=1`, addr 0x1000, `m_addr_ok=1` in the same cycle → `data_addr_ok=1`, count=1. Two cycles later `m_data_ok=1`, `m_rdata=0xDEADBEEF` → `data_data_ok=1`, `data_rdata=0xDEADBEEF`, count=0.
- Lock: `inst_req=1` alone with `m_addr_ok=0` for 3 cycles; `data_req` rises in cycle 2 → `m_addr` stays equal to `inst_addr` until the inst `addr_ok`, then data is granted in the next cycle.
- Priority: both requests high, `m_addr_ok=1` → data accepted first, inst second. Responses in order → `data_data_ok`, then `inst_data_ok`.
- Full: `OUT_DEPTH=4`, four data reads accepted with no responses → on the 5th request `m_req=0`. One `m_data_ok` → count=3, `m_req` reasserts the next cycle.
- Wrap: 10 alternating I/D requests with responses lagging 2 cycles → every `data_ok` is routed to the correct master across pointer wrap.
- Unexpected response: `m_data_ok=1` with count=0 → no master `data_ok`, `err_unexp=1`, held until reset; after reset → 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Shares one SRAM-like slave port between the instruction-fetch master and the
// data master. The data master wins a free grant. A grant stays locked while its
// request waits for addr_ok. An in-order tag FIFO records the owner of each
// accepted request, and each data_ok/rdata is routed back to that owner.
module sram_like_arbiter #(
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // slave
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  // status
  output logic        err_unexp
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t               state_r;
  logic                 grant_i_s;
  logic                 grant_d_s;
  logic                 full_s;
  logic                 m_req_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 head_s;
  logic                 nonempty_s;
  logic [OUT_DEPTH-1:0] tag_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 err_r;

  // Grant selection: the lock owner wins. When no master holds the lock, data has priority over inst.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_req) begin
          grant_d_s = 1'b1;
        end else if (inst_req) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b0;
        end
      end
      LOCK_I:  grant_i_s = 1'b1;
      LOCK_D:  grant_d_s = 1'b1;
      default: begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    endcase
  end

  assign full_s     = (count_r == DEPTH_C);
  assign nonempty_s = (count_r != {CNT_W{1'b0}});
  assign m_req_s    = ((grant_i_s & inst_req) | (grant_d_s & data_req)) & ~full_s;
  assign push_s     = m_req_s & m_addr_ok;
  assign pop_s      = m_data_ok & nonempty_s;
  assign head_s     = tag_r[rd_ptr_r];

  // Slave payload mux: the fields come from the granted master, or are zero when no master is granted.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (grant_d_s) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else if (grant_i_s) begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end else begin
      m_wr    = 1'b0;
      m_size  = 2'd0;
      m_addr  = 32'd0;
      m_wdata = 32'd0;
    end
  end

  assign m_req        = m_req_s;
  assign inst_addr_ok = m_addr_ok & m_req_s & grant_i_s;
  assign data_addr_ok = m_addr_ok & m_req_s & grant_d_s;
  assign inst_data_ok = pop_s & ~head_s;
  assign data_data_ok = pop_s & head_s;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_unexp    = err_r;

  // Grant lock FSM: lock when a request is stalled on addr_ok. Release when the slave accepts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (m_req_s && !m_addr_ok) begin
            state_r <= grant_d_s ? LOCK_D : LOCK_I;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCK_I, LOCK_D: begin
          if (m_req_s && m_addr_ok) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Owner tag FIFO: push on acceptance and pop on an expected response. Both pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_r    <= {OUT_DEPTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tag_r[wr_ptr_r] <= grant_d_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flag: set when a response arrives with no outstanding owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (m_data_ok && !nonempty_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Table-driven bench for sram_like_arbiter (OUT_DEPTH = 4).
// Each record describes one clock cycle: its inputs and the expected outputs in that cycle.
module tb_sram_like_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err_unexp;

  int n_vec = 0;
  int n_bad = 0;

  sram_like_arbiter #(.OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // g: expected grant (0 = none, 1 = inst, 2 = data)
  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        maok;
    logic        mdok;
    logic [31:0] mrdata;
    logic [1:0]  g;
    logic        mreq;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic        ddok;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ireq, input logic [31:0] iaddr,
                              input logic dreq, input logic [31:0] daddr,
                              input logic maok, input logic mdok, input logic [31:0] mrdata,
                              input logic [1:0] g, input logic mreq, input logic iaok,
                              input logic daok, input logic idok, input logic ddok,
                              input logic err);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.maok = maok; v.mdok = mdok; v.mrdata = mrdata; v.g = g; v.mreq = mreq;
    v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok; v.err = err;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge, then compare just after that.
  task automatic apply(input vec_t v, input string name);
    logic [136:0] act, exp;
    logic         e_wr;
    logic [1:0]   e_size;
    logic [31:0]  e_addr, e_wdata;
    @(negedge clk);
    reset      = v.rst;
    inst_req   = v.ireq;
    inst_addr  = v.iaddr;
    inst_wr    = v.iaddr[4];
    inst_size  = v.iaddr[3:2];
    inst_wdata = v.iaddr ^ 32'h1111_0000;
    data_req   = v.dreq;
    data_addr  = v.daddr;
    data_wr    = v.daddr[4];
    data_size  = v.daddr[3:2];
    data_wdata = v.daddr ^ 32'h2222_0000;
    m_addr_ok  = v.maok;
    m_data_ok  = v.mdok;
    m_rdata    = v.mrdata;
    #1;
    e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wdata = 32'd0;
    if (v.g == 2'd1) begin
      e_wr = inst_wr; e_size = inst_size; e_addr = inst_addr; e_wdata = inst_wdata;
    end else if (v.g == 2'd2) begin
      e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
    end
    exp = {v.mreq, e_wr, e_size, e_addr, e_wdata, v.iaok, v.daok, v.idok, v.ddok,
           v.mrdata, v.mrdata, v.err};
    act = {m_req, m_wr, m_size, m_addr, m_wdata, inst_addr_ok, data_addr_ok,
           inst_data_ok, data_data_ok, inst_rdata, data_rdata, err_unexp};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got req/wr/size/addr/wdata/iaok/daok/idok/ddok/ird/drd/err=%h required %h",
               name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;

    //               rst   ireq  iaddr         dreq  daddr         maok  mdok  mrdata        g     mreq  iaok  daok  idok  ddok  err
    // reset state
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h5A5A_0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // single read
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h1000,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // lock: inst stalls, data arrives but inst keeps the grant
    vecs.push_back(mk(1'b0, 1'b1, 32'h2014,    1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h2014,    1'b1, 32'h3008,    1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h2014,    1'b1, 32'h3008,    1'b1, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h3008,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0011, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0022, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // priority: both requesting, data first
    vecs.push_back(mk(1'b0, 1'b1, 32'h4004,    1'b1, 32'h501C,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h4004,    1'b0, 32'h0,       1'b1, 1'b0, 32'h0,         2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'hAAAA_0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'hAAAA_0002, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    // full: four data accepted, fifth blocked, one pop still blocked (conservative), then reasserts
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h6000,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h6014,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h6028,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h603C,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h6040,    1'b1, 1'b0, 32'h0,         2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h6040,    1'b1, 1'b1, 32'hBBBB_0001, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h6040,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1'b0, 1'b0, 32'h0,     1'b0, 32'h0,       1'b0, 1'b1, 32'hBBBB_0010 + 32'(i), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    // unexpected response with empty FIFO: flag is sticky until reset
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'hCCCC_0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // response in the same cycle as the acceptance that would own it
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h7000,    1'b1, 1'b1, 32'hCCCC_0002, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // reset mid-transaction drops the outstanding tag
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h7104,    1'b1, 1'b0, 32'h0,         2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'hCCCC_0003, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Wrap: 10 alternating I/D requests (I first), responses lagging two cycles,
    // so both FIFO pointers wrap past depth 4 while the FIFO holds two entries.
    for (int k = 0; k < 12; k++) begin
      logic is_i, rsp, rsp_i;
      is_i  = ((k % 2) == 0);
      rsp   = (k >= 2);
      rsp_i = (((k - 2) % 2) == 0);
      v = mk(1'b0,
             (k < 10) && is_i,  32'h8000 + 32'(k * 16),
             (k < 10) && !is_i, 32'h9000 + 32'(k * 16),
             (k < 10), rsp, 32'hE000_0000 + 32'(k),
             (k < 10) ? (is_i ? 2'd1 : 2'd2) : 2'd0,
             (k < 10), (k < 10) && is_i, (k < 10) && !is_i,
             rsp && rsp_i, rsp && !rsp_i, 1'b0);
      apply(v, $sformatf("wrap%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
